// File: rtl/reaction_timer.sv
// Reaction-time measurement stage: lights the stimulus LED on the delay stage's
// rising output and reports the press latency in ms, an early press, or a timeout.
module reaction_timer #(
    parameter int CLK_HZ = 100_000_000,
    parameter int MAX_MS = 9999,
    parameter int MS_W   = 14
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            arm_i,
    input  logic            stim_i,
    input  logic            btn_i,
    output logic            led_o,
    output logic [MS_W-1:0] time_ms_o,
    output logic            valid_o,
    output logic            early_o,
    output logic            timeout_o,
    output logic            done_o
);

    localparam int TICKS_PER_MS = CLK_HZ / 1000;
    localparam int TICK_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_MS - 1);
    localparam logic [MS_W-1:0]   MS_LIMIT  = MS_W'(MAX_MS);

    typedef enum logic [1:0] {IDLE, WAIT_STIM, MEASURE, DONE} state_e;

    state_e            state_q;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [MS_W-1:0]   ms_q, ms_d, time_ms_q;
    logic              stim_q, btn_q;
    logic              led_q, valid_q, early_q, timeout_q, done_q;
    logic              stimRise, btnRise, tickWrap;

    assign stimRise = stim_i & ~stim_q;
    assign btnRise  = btn_i & ~btn_q;
    assign tickWrap = (tick_q == TICK_LAST);

    always_comb begin
        tick_d = tickWrap ? '0 : tick_q + 1'b1;
        ms_d   = tickWrap ? ms_q + 1'b1 : ms_q;
    end

    // Edge-history registers come out of reset high so a level already present is not a press.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            stim_q    <= 1'b1;
            btn_q     <= 1'b1;
            tick_q    <= '0;
            ms_q      <= '0;
            time_ms_q <= '0;
            led_q     <= 1'b0;
            valid_q   <= 1'b0;
            early_q   <= 1'b0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            stim_q <= stim_i;
            btn_q  <= btn_i;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (arm_i) begin
                        state_q   <= WAIT_STIM;
                        time_ms_q <= '0;
                        valid_q   <= 1'b0;
                        early_q   <= 1'b0;
                        timeout_q <= 1'b0;
                    end
                end
                WAIT_STIM: begin
                    if (!arm_i) begin
                        state_q <= IDLE;
                    end else if (btnRise) begin
                        early_q <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (stimRise) begin
                        led_q   <= 1'b1;
                        tick_q  <= '0;
                        ms_q    <= '0;
                        state_q <= MEASURE;
                    end
                end
                MEASURE: begin
                    // A press on the final tick still counts as a measurement, not a timeout.
                    if (!arm_i) begin
                        led_q   <= 1'b0;
                        state_q <= IDLE;
                    end else if (btnRise) begin
                        time_ms_q <= ms_q;
                        valid_q   <= 1'b1;
                        led_q     <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end else if (tickWrap && (ms_q == MS_LIMIT)) begin
                        time_ms_q <= MS_LIMIT;
                        timeout_q <= 1'b1;
                        led_q     <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        tick_q <= tick_d;
                        ms_q   <= ms_d;
                    end
                end
                DONE: begin
                    led_q <= 1'b0;
                    if (!arm_i) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    tick_q    <= '0;
                    ms_q      <= '0;
                    time_ms_q <= '0;
                    led_q     <= 1'b0;
                    valid_q   <= 1'b0;
                    early_q   <= 1'b0;
                    timeout_q <= 1'b0;
                end
            endcase
        end
    end

    assign led_o     = led_q;
    assign time_ms_o = time_ms_q;
    assign valid_o   = valid_q;
    assign early_o   = early_q;
    assign timeout_o = timeout_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_reaction_timer.sv
// Bench for reaction_timer: randomized rounds against a cycle-offset reference
// model, with expected results queued and popped by a done-pulse monitor.
module tb_reaction_timer;

    localparam int CLK_HZ = 4000;
    localparam int MAX_MS = 20;
    localparam int MS_W   = 5;
    localparam int TPM    = CLK_HZ / 1000;
    localparam int LIMIT  = (MAX_MS + 1) * TPM;

    typedef struct packed {
        logic            valid;
        logic            early;
        logic            timeout;
        logic [MS_W-1:0] ms;
    } result_t;

    logic            clk = 1'b0;
    logic            rst, arm, stim, btn;
    logic            led_o, valid_o, early_o, timeout_o, done_o;
    logic [MS_W-1:0] time_ms_o;

    int      tests = 0;
    int      fails = 0;
    result_t expQ[$];
    result_t lastExp;
    result_t monExp;

    reaction_timer #(.CLK_HZ(CLK_HZ), .MAX_MS(MAX_MS), .MS_W(MS_W)) dut (
        .clk_i(clk), .rst_i(rst), .arm_i(arm), .stim_i(stim), .btn_i(btn),
        .led_o(led_o), .time_ms_o(time_ms_o), .valid_o(valid_o),
        .early_o(early_o), .timeout_o(timeout_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Stim is sampled at edge s and the press at edge p; the model works purely
    // from the distance p-s in clock edges.
    function automatic result_t modelRound(input int s, input int p);
        result_t r;
        r = '0;
        if (p != 0 && p <= s) begin
            r.early = 1'b1;
        end else if (p != 0 && (p - s) <= LIMIT) begin
            r.valid = 1'b1;
            r.ms    = MS_W'((p - s - 1) / TPM);
        end else begin
            r.timeout = 1'b1;
            r.ms      = MS_W'(MAX_MS);
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (done_o) begin
            if (expQ.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_done: got done=1, expected no result pending");
            end else begin
                monExp = expQ.pop_front();
                checkOutput("done_result", int'({valid_o, early_o, timeout_o, time_ms_o}), int'(monExp));
                checkOutput("done_led", int'(led_o), 0);
            end
        end
    end

    // One round: arm at cycle 0, stim from cycle s, button held from cycle p (0 = never),
    // optional arm drop at cycle abortAt.
    task automatic applyStimulus(input int s, input int p, input int abortAt, input bit holdArm);
        bit      isEarly;
        int      ledEnd, endC, ledErr, ledExp;
        result_t e;
        isEarly = (p != 0 && p <= s);
        ledEnd  = (p != 0 && (p - s) <= LIMIT) ? p : s + LIMIT;
        if (abortAt != 0) ledEnd = abortAt;
        endC = isEarly ? (((s > p) ? s : p) + 3) : (ledEnd + 3);
        if (abortAt == 0) begin
            e = modelRound(s, p);
            expQ.push_back(e);
            lastExp = e;
        end
        ledErr = 0;
        for (int c = 0; c <= endC; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                ledExp = (!isEarly && c >= s + 1 && c <= ledEnd) ? 1 : 0;
                if (int'(led_o) != ledExp) ledErr++;
            end
            if (c == 1) checkOutput("arm_clears_flags", int'({valid_o, early_o, timeout_o}), 0);
            arm  = (abortAt == 0) || (c < abortAt);
            stim = (c >= s);
            btn  = (p != 0) && (c >= p);
        end
        checkOutput("led_wrong_cycles", ledErr, 0);
        if (abortAt != 0) checkOutput("abort_flags", int'({valid_o, early_o, timeout_o}), 0);
        checkOutput("result_pending", expQ.size(), 0);
        if (!holdArm) begin
            @(negedge clk);
            arm = 1'b0; stim = 1'b0; btn = 1'b0;
            repeat (3) @(negedge clk);
            if (abortAt == 0)
                checkOutput("held_result", int'({valid_o, early_o, timeout_o, time_ms_o}), int'(lastExp));
        end
    endtask

    task automatic resetMidMeasure();
        @(negedge clk); arm = 1'b1; stim = 1'b0; btn = 1'b0;
        repeat (2) @(negedge clk); stim = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("led_measuring", int'(led_o), 1);
        rst = 1'b1; btn = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_measure", int'({led_o, time_ms_o, valid_o, early_o, timeout_o, done_o}), 0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("held_btn_ignored", int'({led_o, early_o, valid_o, timeout_o}), 0);
        arm = 1'b0; stim = 1'b0; btn = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int s, p, mode;
        rst = 1'b1; arm = 1'b0; stim = 1'b0; btn = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_state", int'({led_o, time_ms_o, valid_o, early_o, timeout_o, done_o}), 0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(3, 3 + 4 * 7 + 2, 0, 1'b0);
        applyStimulus(8, 2, 0, 1'b0);
        applyStimulus(2, 0, 0, 1'b0);
        applyStimulus(5, 5, 0, 1'b0);
        applyStimulus(2, 2 + LIMIT, 0, 1'b0);
        applyStimulus(2, 2 + LIMIT + 1, 0, 1'b0);
        applyStimulus(4, 4 + 1, 0, 1'b0);
        applyStimulus(3, 0, 3 + 20, 1'b0);
        applyStimulus(2, 2 + 50, 0, 1'b0);
        resetMidMeasure();
        applyStimulus(2, 2 + 10, 0, 1'b1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_in_done", int'({led_o, time_ms_o, valid_o, early_o, timeout_o, done_o}), 0);
        rst = 1'b0; arm = 1'b0; stim = 1'b0; btn = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 30; i++) begin
            s    = int'($urandom_range(1, 8));
            mode = int'($urandom_range(0, 3));
            case (mode)
                0: applyStimulus(s, int'($urandom_range(1, s)), 0, 1'b0);
                1: applyStimulus(s, s + int'($urandom_range(1, LIMIT)), 0, 1'b0);
                2: begin
                    p = ($urandom_range(0, 1) == 0) ? 0 : s + LIMIT + int'($urandom_range(1, 6));
                    applyStimulus(s, p, 0, 1'b0);
                end
                default: applyStimulus(s, 0, s + int'($urandom_range(1, LIMIT - 1)), 1'b0);
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
